// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU; holds one registered result per grant.
// Latency: 1 cycle from accept (req_ready) to rsp_valid; back-to-back grant when the held result is taken.
// Backpressure: req_ready stays low while a held result waits for rsp_ready of its owner.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready [1:0]   per-requester operation handshake (ready is combinational)
//   req{0,1}_a/_b/_f            operands and function code of each requester
//   rsp_valid/rsp_ready [1:0]   per-requester result handshake, rsp_data is the held result
//   alu_a/alu_b/alu_f, alu_s    shared ALU operands out, combinational result in
//
// Build option: ALU_ARB_FIXED_PRIO_EN -> requester 0 always wins, no last-grant pointer.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_f,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_f,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_f,
    input  logic [31:0] alu_s
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t state;
    logic   owner;       // requester whose result is held in rsp_data
    logic   grant_opp;   // a new operation may be accepted this cycle
    logic   grant_any;   // an operation is accepted this cycle
    logic   grant_sel;   // index of the accepted requester

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic   last_grant;
`endif

    always_comb begin
        // In RESP the owner's rsp_valid is high by construction, so the owner's
        // rsp_ready alone marks the response handshake.
        grant_opp = (state == IDLE) || rsp_ready[owner];
        grant_any = grant_opp && (|req_valid) && !rst;

`ifdef ALU_ARB_FIXED_PRIO_EN
        grant_sel = ~req_valid[0];
`else
        if (&req_valid) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = req_valid[1];
        end
`endif

        req_ready = 2'b00;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_f     = 3'b000;
        if (grant_any) begin
            if (grant_sel) begin
                req_ready = 2'b10;
                alu_a     = req1_a;
                alu_b     = req1_b;
                alu_f     = req1_f;
            end else begin
                req_ready = 2'b01;
                alu_a     = req0_a;
                alu_b     = req0_b;
                alu_f     = req0_f;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_data   <= 32'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;   // requester 0 wins the first contention
`endif
        end else if (grant_any) begin
            state      <= RESP;
            owner      <= grant_sel;
            rsp_valid  <= grant_sel ? 2'b10 : 2'b01;
            rsp_data   <= alu_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= grant_sel;
`endif
        end else if ((state == RESP) && rsp_ready[owner]) begin
            // result taken, nothing new: rsp_data keeps its last value
            state      <= IDLE;
            rsp_valid  <= 2'b00;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a scoreboard queue of expected responses.
// Latency: checks accept-to-rsp_valid of one cycle and back-to-back grants.
// Backpressure: holds rsp_ready low to check result stability and req_ready gating.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic [2:0]  req0_f = 3'd0, req1_f = 3'd0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_data;
    logic [31:0] alu_a, alu_b, alu_s;
    logic [2:0]  alu_f;

    // operands applied together with the next req_valid/rsp_ready change
    logic [31:0] n_a0 = 32'd0, n_b0 = 32'd0, n_a1 = 32'd0, n_b1 = 32'd0;
    logic [2:0]  n_f0 = 3'd0, n_f1 = 3'd0;

    typedef struct packed {
        logic        who;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    // shared ALU, the environment around the arbiter
    always_comb begin
        case (alu_f)
            3'b000:  alu_s = alu_a + alu_b;
            3'b001:  alu_s = alu_a - alu_b;
            3'b010:  alu_s = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b011:  alu_s = {31'd0, alu_a < alu_b};
            3'b100:  alu_s = alu_a ^ alu_b;
            3'b110:  alu_s = alu_a | alu_b;
            3'b111:  alu_s = alu_a & alu_b;
            default: alu_s = 32'd0;
        endcase
    end

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_s(alu_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle: apply inputs just after the rising edge, return at the falling edge
    task automatic drive(input logic [1:0] rv, input logic [1:0] rr);
        @(posedge clk);
        #1;
        req_valid = rv;
        rsp_ready = rr;
        req0_a = n_a0; req0_b = n_b0; req0_f = n_f0;
        req1_a = n_a1; req1_b = n_b1; req1_f = n_f1;
        @(negedge clk);
    endtask

    task automatic step(input logic [1:0] rv, input logic [1:0] rr,
                        input logic [1:0] exp_rdy, input logic [31:0] exp_dat,
                        input string name);
        exp_t e;
        drive(rv, rr);
        chk(name, {30'd0, req_ready}, {30'd0, exp_rdy});
        if (exp_rdy != 2'b00) begin
            e.who = exp_rdy[1];
            e.dat = exp_dat;
            sb.push_back(e);
        end
    endtask

    // monitor: every response handshake pops one expected result
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    exp_t e;
                    nvec++;
                    if (sb.size() == 0) begin
                        nerr++;
                        $display("FAIL rsp_unexpected: requester %0d data 0x%08h, expected no response", i, rsp_data);
                    end else begin
                        e = sb.pop_front();
                        if ((e.who != 1'(i)) || (rsp_data !== e.dat)) begin
                            nerr++;
                            $display("FAIL rsp: requester %0d data 0x%08h, expected requester %0d data 0x%08h",
                                     i, rsp_data, e.who, e.dat);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with both requesters asking: nothing may be accepted
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst = 1'b0;

        // single request: 5 - 3, accepted same cycle, result next cycle
        n_a0 = 32'd5; n_b0 = 32'd3; n_f0 = 3'b001;
        step(2'b01, 2'b00, 2'b01, 32'd2, "sub_accept");
        step(2'b00, 2'b01, 2'b00, 32'd0, "sub_no_grant");
        chk("sub_latency_valid", {30'd0, rsp_valid}, 32'd1);
        chk("sub_latency_data", rsp_data, 32'd2);

        // hold the result while requester 1 waits
        n_a0 = 32'h0000_00F0; n_b0 = 32'h0000_000F; n_f0 = 3'b110;
        n_a1 = 32'h1234_5678; n_b1 = 32'h1111_1111; n_f1 = 3'b100;
        step(2'b01, 2'b00, 2'b01, 32'h0000_00FF, "or_accept");
        for (int k = 0; k < 5; k++) begin
            step(2'b10, 2'b00, 2'b00, 32'd0, "hold_ready");
            chk("hold_data", rsp_data, 32'h0000_00FF);
            chk("hold_valid", {30'd0, rsp_valid}, 32'd1);
        end
        step(2'b10, 2'b01, 2'b10, 32'h0325_4769, "b2b_grant_req1");
        step(2'b00, 2'b00, 2'b00, 32'd0, "idle_while_held");
        chk("held_req1_valid", {30'd0, rsp_valid}, 32'd2);
        chk("held_req1_data", rsp_data, 32'h0325_4769);

        // asynchronous reset in the middle of a cycle discards the held result
        #2;
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("async_rst_valid", {30'd0, rsp_valid}, 32'd0);
        chk("async_rst_data", rsp_data, 32'd0);
        chk("async_rst_ready", {30'd0, req_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst = 1'b0;

        // contention with rsp_ready=11: requester 0 wins first after reset
        n_a0 = 32'd10; n_b0 = 32'd20; n_f0 = 3'b000;
        n_a1 = 32'hFFFF_FFFF; n_b1 = 32'd1; n_f1 = 3'b010;
`ifdef ALU_ARB_FIXED_PRIO_EN
        step(2'b11, 2'b11, 2'b01, 32'd30, "fix_g0");
        step(2'b11, 2'b11, 2'b01, 32'd30, "fix_g1");
        n_f1 = 3'b011;
        step(2'b11, 2'b11, 2'b01, 32'd30, "fix_g2");
        step(2'b11, 2'b11, 2'b01, 32'd30, "fix_g3");
`else
        step(2'b11, 2'b11, 2'b01, 32'd30, "rr_g0");
        step(2'b11, 2'b11, 2'b10, 32'd1,  "rr_g1_slt");
        n_f1 = 3'b011;
        step(2'b11, 2'b11, 2'b01, 32'd30, "rr_g2");
        step(2'b11, 2'b11, 2'b10, 32'd0,  "rr_g3_sltu");
`endif
        step(2'b10, 2'b11, 2'b10, 32'd0, "only_req1");
        step(2'b00, 2'b11, 2'b00, 32'd0, "drain");

        // idle: ALU driven to zero even with nonzero requester operands
        step(2'b00, 2'b00, 2'b00, 32'd0, "idle_ready");
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
        chk("idle_alu_f", {29'd0, alu_f}, 32'd0);
        chk("idle_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
